// File: rtl/hazard_unit.sv
// Hazard detection, forwarding and stall monitor for the 5-stage MIPS pipeline.
// Zero-latency forward/stall/flush decode plus saturating stall statistics and a hang watchdog.
module hazard_unit #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_ID_HU,
  input  logic [4:0]       Rt_ID_HU,
  input  logic [4:0]       Rs_EX_HU,
  input  logic [4:0]       Rt_EX_HU,
  input  logic [4:0]       WriteReg_EX_HU,
  input  logic [4:0]       WriteReg_MEM_HU,
  input  logic [4:0]       WriteReg_WB_HU,
  input  logic             RegWrite_EX_HU,
  input  logic             RegWrite_MEM_HU,
  input  logic             RegWrite_WB_HU,
  input  logic             MemtoReg_EX_HU,
  input  logic             MemtoReg_MEM_HU,
  input  logic             Branch_ID_HU,
  input  logic             hold,
  input  logic             clr_cnt,
  input  logic             clr_err,
  output logic [1:0]       fwdA_EX_HU,
  output logic [1:0]       fwdB_EX_HU,
  output logic             SrcAfwd_ID,
  output logic             SrcBfwd_ID,
  output logic             Stall_IF_HU,
  output logic             Stall_ID_HU,
  output logic             Flush_EX_HU,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             hang_err
);

  localparam int            CW          = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CONSEC_MAX  = CW'(MAX_STALL);
  localparam logic [CW-1:0] CONSEC_TRIP = CW'(MAX_STALL - 1);

  typedef enum logic [1:0] {IDLE, STALLING, HUNG} wd_state_e;

  // $zero is hardwired, so a write to it can never be a real producer.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wr_mem,
                                         input logic we_mem, input logic [4:0] wr_wb,
                                         input logic we_wb);
    if (we_mem && hit(src, wr_mem))     return 2'b10;
    else if (we_wb && hit(src, wr_wb))  return 2'b01;
    else                                return 2'b00;
  endfunction

  logic lwstall, brstall, hz, counted;

  assign fwdA_EX_HU = fwd_sel(Rs_EX_HU, WriteReg_MEM_HU, RegWrite_MEM_HU, WriteReg_WB_HU, RegWrite_WB_HU);
  assign fwdB_EX_HU = fwd_sel(Rt_EX_HU, WriteReg_MEM_HU, RegWrite_MEM_HU, WriteReg_WB_HU, RegWrite_WB_HU);
  assign SrcAfwd_ID = RegWrite_MEM_HU && hit(Rs_ID_HU, WriteReg_MEM_HU);
  assign SrcBfwd_ID = RegWrite_MEM_HU && hit(Rt_ID_HU, WriteReg_MEM_HU);

  // Load-use deliberately compares raw IDs, register 0 included.
  assign lwstall = MemtoReg_EX_HU && ((Rt_EX_HU == Rs_ID_HU) || (Rt_EX_HU == Rt_ID_HU));
  assign brstall = Branch_ID_HU &&
                   ((RegWrite_EX_HU  && (hit(WriteReg_EX_HU, Rs_ID_HU)  || hit(WriteReg_EX_HU, Rt_ID_HU))) ||
                    (MemtoReg_MEM_HU && (hit(WriteReg_MEM_HU, Rs_ID_HU) || hit(WriteReg_MEM_HU, Rt_ID_HU))));
  assign hz      = lwstall || brstall;
  assign counted = !hold;

  assign Stall_IF_HU = hz || hold;
  assign Stall_ID_HU = hz || hold;
  assign Flush_EX_HU = hz || hold;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_stall_cnt <= '0;
      br_stall_cnt <= '0;
      stall_cnt    <= '0;
    end else if (clr_cnt) begin
      lw_stall_cnt <= '0;
      br_stall_cnt <= '0;
      stall_cnt    <= '0;
    end else if (counted) begin
      if (lwstall && lw_stall_cnt != '1) lw_stall_cnt <= lw_stall_cnt + 1'b1;
      if (brstall && br_stall_cnt != '1) br_stall_cnt <= br_stall_cnt + 1'b1;
      if (hz      && stall_cnt    != '1) stall_cnt    <= stall_cnt + 1'b1;
    end
  end

  wd_state_e     state_q, state_d;
  logic [CW-1:0] consec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      consec  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HUNG && clr_err) consec <= '0;
      else if (counted) begin
        if (!hz)                      consec <= '0;
        else if (consec != CONSEC_MAX) consec <= consec + 1'b1;
      end
    end
  end

  // NOTE: next state defaults to the current state so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (counted && hz) state_d = STALLING;
      STALLING: if (counted) begin
        if (!hz)                         state_d = IDLE;
        else if (consec == CONSEC_TRIP)  state_d = HUNG;
      end
      HUNG:     if (clr_err) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign hang_err = (state_q == HUNG);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized bench for hazard_unit against a rule-level reference model.
module tb_hazard_unit;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 8;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk, reset;
  logic [4:0] Rs_ID_HU, Rt_ID_HU, Rs_EX_HU, Rt_EX_HU;
  logic [4:0] WriteReg_EX_HU, WriteReg_MEM_HU, WriteReg_WB_HU;
  logic RegWrite_EX_HU, RegWrite_MEM_HU, RegWrite_WB_HU;
  logic MemtoReg_EX_HU, MemtoReg_MEM_HU, Branch_ID_HU;
  logic hold, clr_cnt, clr_err;
  logic [1:0] fwdA_EX_HU, fwdB_EX_HU;
  logic SrcAfwd_ID, SrcBfwd_ID, Stall_IF_HU, Stall_ID_HU, Flush_EX_HU;
  logic [CNT_W-1:0] lw_stall_cnt, br_stall_cnt, stall_cnt;
  logic hang_err;

  hazard_unit #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset),
    .Rs_ID_HU(Rs_ID_HU), .Rt_ID_HU(Rt_ID_HU), .Rs_EX_HU(Rs_EX_HU), .Rt_EX_HU(Rt_EX_HU),
    .WriteReg_EX_HU(WriteReg_EX_HU), .WriteReg_MEM_HU(WriteReg_MEM_HU), .WriteReg_WB_HU(WriteReg_WB_HU),
    .RegWrite_EX_HU(RegWrite_EX_HU), .RegWrite_MEM_HU(RegWrite_MEM_HU), .RegWrite_WB_HU(RegWrite_WB_HU),
    .MemtoReg_EX_HU(MemtoReg_EX_HU), .MemtoReg_MEM_HU(MemtoReg_MEM_HU), .Branch_ID_HU(Branch_ID_HU),
    .hold(hold), .clr_cnt(clr_cnt), .clr_err(clr_err),
    .fwdA_EX_HU(fwdA_EX_HU), .fwdB_EX_HU(fwdB_EX_HU), .SrcAfwd_ID(SrcAfwd_ID), .SrcBfwd_ID(SrcBfwd_ID),
    .Stall_IF_HU(Stall_IF_HU), .Stall_ID_HU(Stall_ID_HU), .Flush_EX_HU(Flush_EX_HU),
    .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt), .stall_cnt(stall_cnt),
    .hang_err(hang_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counters and a run-length watchdog.
  int m_lw, m_br, m_st, m_run;
  bit m_hung;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
    return a != 5'd0 && a == b;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (RegWrite_MEM_HU && same_reg(src, WriteReg_MEM_HU)) return 2'b10;
    if (RegWrite_WB_HU  && same_reg(src, WriteReg_WB_HU))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [4:0] dst, input bit zero_ok);
    if (zero_ok) return dst == Rs_ID_HU || dst == Rt_ID_HU;
    return same_reg(dst, Rs_ID_HU) || same_reg(dst, Rt_ID_HU);
  endfunction

  function automatic bit ref_lw();
    return MemtoReg_EX_HU && reads(Rt_EX_HU, 1'b1);
  endfunction

  function automatic bit ref_br();
    return Branch_ID_HU && ((RegWrite_EX_HU && reads(WriteReg_EX_HU, 1'b0)) ||
                            (MemtoReg_MEM_HU && reads(WriteReg_MEM_HU, 1'b0)));
  endfunction

  task automatic model_reset();
    m_lw = 0; m_br = 0; m_st = 0; m_run = 0; m_hung = 0;
  endtask

  task automatic model_update();
    bit lw, br;
    lw = ref_lw();
    br = ref_br();
    if (clr_cnt) begin
      m_lw = 0; m_br = 0; m_st = 0;
    end else if (!hold) begin
      if (lw)       m_lw = (m_lw < CMAX) ? m_lw + 1 : CMAX;
      if (br)       m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (lw || br) m_st = (m_st < CMAX) ? m_st + 1 : CMAX;
    end
    if (m_hung) begin
      if (clr_err) begin m_hung = 0; m_run = 0; end
    end else if (!hold) begin
      if (lw || br) begin
        m_run++;
        if (m_run >= MAX_STALL) m_hung = 1;
      end else m_run = 0;
    end
  endtask

  task automatic check_all();
    bit hz;
    hz = ref_lw() || ref_br();
    check("fwdA",     32'(fwdA_EX_HU),   32'(ref_fwd(Rs_EX_HU)));
    check("fwdB",     32'(fwdB_EX_HU),   32'(ref_fwd(Rt_EX_HU)));
    check("srcAfwd",  32'(SrcAfwd_ID),   32'(RegWrite_MEM_HU && same_reg(Rs_ID_HU, WriteReg_MEM_HU)));
    check("srcBfwd",  32'(SrcBfwd_ID),   32'(RegWrite_MEM_HU && same_reg(Rt_ID_HU, WriteReg_MEM_HU)));
    check("stall_if", 32'(Stall_IF_HU),  32'(hz || hold));
    check("stall_id", 32'(Stall_ID_HU),  32'(hz || hold));
    check("flush_ex", 32'(Flush_EX_HU),  32'(hz || hold));
    check("lw_cnt",   32'(lw_stall_cnt), m_lw);
    check("br_cnt",   32'(br_stall_cnt), m_br);
    check("st_cnt",   32'(stall_cnt),    m_st);
    check("hang_err", 32'(hang_err),     32'(m_hung));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    Rs_ID_HU = 0; Rt_ID_HU = 0; Rs_EX_HU = 0; Rt_EX_HU = 0;
    WriteReg_EX_HU = 0; WriteReg_MEM_HU = 0; WriteReg_WB_HU = 0;
    RegWrite_EX_HU = 0; RegWrite_MEM_HU = 0; RegWrite_WB_HU = 0;
    MemtoReg_EX_HU = 0; MemtoReg_MEM_HU = 0; Branch_ID_HU = 0;
    hold = 0; clr_cnt = 0; clr_err = 0;
  endtask

  task automatic set_lw_hazard();
    clear_inputs();
    MemtoReg_EX_HU = 1; Rt_EX_HU = 8; Rs_ID_HU = 8;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_reset();
    #1 check_all();
    #11 reset = 1'b1;
    cyc();

    // Forwarding priority: MEM over WB, register 0 never forwards.
    Rs_EX_HU = 5; WriteReg_MEM_HU = 5; WriteReg_WB_HU = 5; RegWrite_MEM_HU = 1; RegWrite_WB_HU = 1;
    #1 check("fwd_mem_prio", 32'(fwdA_EX_HU), 32'd2);
    RegWrite_MEM_HU = 0;
    #1 check("fwd_wb", 32'(fwdA_EX_HU), 32'd1);
    Rs_EX_HU = 0;
    #1 check("fwd_r0", 32'(fwdA_EX_HU), 32'd0);
    cyc();

    // Load-use stall and its counters one cycle later.
    set_lw_hazard();
    #1 check("lw_stall", 32'({Stall_IF_HU, Stall_ID_HU, Flush_EX_HU}), 32'h7);
    cyc();
    clear_inputs();
    #1 check("lw_cnt_1", 32'(lw_stall_cnt), 32'd1);
    check("st_cnt_1", 32'(stall_cnt), 32'd1);
    cyc();

    // Branch hazard on EX producer, then a non-load MEM producer forwards instead.
    Branch_ID_HU = 1; Rt_ID_HU = 3; RegWrite_EX_HU = 1; WriteReg_EX_HU = 3;
    #1 check("br_stall", 32'(Stall_ID_HU), 32'd1);
    cyc();
    RegWrite_EX_HU = 0; WriteReg_EX_HU = 0; WriteReg_MEM_HU = 3; RegWrite_MEM_HU = 1; MemtoReg_MEM_HU = 0;
    #1 check("br_cnt_1", 32'(br_stall_cnt), 32'd1);
    check("br_nostall", 32'(Stall_ID_HU), 32'd0);
    check("srcB_mem", 32'(SrcBfwd_ID), 32'd1);
    cyc();

    // Watchdog trips after MAX_STALL counted hazard cycles and stays sticky.
    set_lw_hazard();
    repeat (MAX_STALL - 1) cyc();
    check("wd_not_yet", 32'(hang_err), 32'd0);
    cyc();
    check("wd_trip", 32'(hang_err), 32'd1);
    clear_inputs();
    repeat (2) cyc();
    check("wd_sticky", 32'(hang_err), 32'd1);
    clr_err = 1;
    cyc();
    clr_err = 0;
    #1 check("wd_clr", 32'(hang_err), 32'd0);

    // A hold gap inside the run neither extends nor breaks it.
    set_lw_hazard();
    repeat (4) cyc();
    hold = 1;
    repeat (2) cyc();
    hold = 0;
    repeat (3) cyc();
    check("wd_gap_7", 32'(hang_err), 32'd0);
    cyc();
    check("wd_gap_8", 32'(hang_err), 32'd1);

    // clr_err with a live hazard: back to idle, then a fresh run starts.
    clr_err = 1;
    cyc();
    clr_err = 0;
    check("wd_clr_hz", 32'(hang_err), 32'd0);
    cyc();
    check("wd_restart", 32'(hang_err), 32'd0);
    clear_inputs();
    cyc();

    // Saturation and clear-over-increment.
    set_lw_hazard();
    repeat (20) cyc();
    check("st_sat", 32'(stall_cnt), CMAX);
    clr_cnt = 1;
    cyc();
    clr_cnt = 0;
    #1 check("st_clr", 32'(stall_cnt), 32'd0);
    repeat (3) cyc();

    // Asynchronous reset while hung with nonzero counters, no clock edge.
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_hang", 32'(hang_err), 32'd0);
    check("rst_lw", 32'(lw_stall_cnt), 32'd0);
    check("rst_st", 32'(stall_cnt), 32'd0);
    check("rst_br", 32'(br_stall_cnt), 32'd0);
    check("rst_comb", 32'(Stall_ID_HU), 32'd1);
    model_reset();
    #1 reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Randomized traffic over a small register window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      Rs_ID_HU        = 5'($urandom_range(0, 7));
      Rt_ID_HU        = 5'($urandom_range(0, 7));
      Rs_EX_HU        = 5'($urandom_range(0, 7));
      Rt_EX_HU        = 5'($urandom_range(0, 7));
      WriteReg_EX_HU  = 5'($urandom_range(0, 7));
      WriteReg_MEM_HU = 5'($urandom_range(0, 7));
      WriteReg_WB_HU  = 5'($urandom_range(0, 7));
      RegWrite_EX_HU  = 1'($urandom_range(0, 1));
      RegWrite_MEM_HU = 1'($urandom_range(0, 1));
      RegWrite_WB_HU  = 1'($urandom_range(0, 1));
      MemtoReg_EX_HU  = 1'($urandom_range(0, 1));
      MemtoReg_MEM_HU = 1'($urandom_range(0, 1));
      Branch_ID_HU    = 1'($urandom_range(0, 1));
      hold            = ($urandom_range(0, 7) == 0);
      clr_cnt         = ($urandom_range(0, 15) == 0);
      clr_err         = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard-detection, forwarding and stall-monitor unit for the 5-stage MIPS pipeline. It is the other end of the datapath's hazard interface. It consumes register IDs and control bits from ID, EX, MEM and WB, and returns the forwarding selects, stall enables and the ID/EX flush. It also keeps saturating stall statistics and a watchdog FSM that flags a pipeline stuck in stall.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter
- MAX_STALL, 8, consecutive hazard-stall cycles that trip the watchdog (legal range ≥2)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- Rs_ID_HU, Rt_ID_HU  in  5 each  source registers in ID
- Rs_EX_HU, Rt_EX_HU  in  5 each  source registers in EX
- WriteReg_EX_HU, WriteReg_MEM_HU, WriteReg_WB_HU  in  5 each  destination register per stage
- RegWrite_EX_HU, RegWrite_MEM_HU, RegWrite_WB_HU  in  1 each  register write enable per stage
- MemtoReg_EX_HU, MemtoReg_MEM_HU  in  1 each  load in EX / MEM
- Branch_ID_HU  in  1  beq in ID
- hold  in  1  debug front-end freeze
- clr_cnt  in  1  synchronous clear of statistics
- clr_err  in  1  synchronous clear of hang_err
- fwdA_EX_HU, fwdB_EX_HU  out  2 each  EX forwarding select: 00 = register file, 01 = Result_WB, 10 = ALUResult_MEM
- SrcAfwd_ID, SrcBfwd_ID  out  1 each  ID compare operand taken from ALUResult_MEM
- Stall_IF_HU, Stall_ID_HU  out  1 each  1 holds the PC / IF-ID register
- Flush_EX_HU  out  1  1 clears ID/EX (inserts a bubble)
- lw_stall_cnt, br_stall_cnt, stall_cnt  out  CNT_W each  statistics
- hang_err  out  1  sticky watchdog error

## Operation
Combinational part (no register stage; outputs are a function of the current inputs only):
- Register 0 never matches in any comparison below.
- fwdA = 10 if Rs_EX == WriteReg_MEM and RegWrite_MEM.
- Otherwise fwdA = 01 if Rs_EX == WriteReg_WB and RegWrite_WB.
- Otherwise fwdA = 00. MEM has priority over WB. fwdB is the same using Rt_EX.
- SrcAfwd_ID = Rs_ID == WriteReg_MEM and RegWrite_MEM. SrcBfwd_ID is the same using Rt_ID.
- lwstall = MemtoReg_EX and (Rt_EX == Rs_ID or Rt_EX == Rt_ID). The register-0 exclusion does not apply to lwstall.
- brstall = Branch_ID and ((RegWrite_EX and WriteReg_EX ∈ {Rs_ID, Rt_ID}) or (MemtoReg_MEM and WriteReg_MEM ∈ {Rs_ID, Rt_ID})).
- hz = lwstall or brstall.
- Stall_IF_HU = Stall_ID_HU = Flush_EX_HU = hz or hold.

Sequential part:
- A cycle counts only when hold = 0.
- On a counted cycle:
  - lw_stall_cnt increments if lwstall.
  - br_stall_cnt increments if brstall.
  - stall_cnt increments if hz.
  - When lwstall and brstall are both set, each of its own counter increments and stall_cnt increments once.
- All three counters saturate at 2^CNT_W−1.
- clr_cnt = 1 zeroes all three counters on the next edge and overrides any increment in the same cycle.
- consec, width clog2(MAX_STALL+1):
  - increments on a counted cycle with hz = 1, saturating at MAX_STALL;
  - clears on a counted cycle with hz = 0;
  - holds its value while hold = 1.

Watchdog FSM states: IDLE, STALLING, HUNG.
- IDLE → STALLING: counted cycle with hz = 1.
- STALLING → IDLE: counted cycle with hz = 0.
- STALLING → HUNG: counted cycle with hz = 1 and consec == MAX_STALL−1.
- HUNG → IDLE: only on clr_err = 1 (next edge) or on reset. consec is also cleared on that exit.
- hang_err = 1 exactly when the state is HUNG.
- clr_err in IDLE or STALLING has no effect.
- Stall, forward and flush outputs are unaffected by the FSM state; in HUNG they still follow the hazard logic.

## Timing
- Forwarding, stall and flush outputs have zero latency, settling within the same cycle as their inputs.
- Reset (reset = 0, asynchronous):
  - all counters = 0, consec = 0, state = IDLE, hang_err = 0 immediately;
  - combinational outputs keep following their inputs (all-zero inputs give all-zero outputs).
- Reset deasserting mid-stall: the next cycle starts from IDLE with consec = 0.
- Counter outputs update one cycle after the qualifying cycle.
- hang_err rises in the cycle after the MAX_STALL-th consecutive counted hz cycle. With hold = 0 and hz held high from cycle 0, hang_err = 1 from cycle MAX_STALL.
- hold cycles inside a stall run neither extend nor break the run.
- clr_err and a new hz in the same cycle while in HUNG: the FSM goes to IDLE, then re-enters STALLING on the next counted hz cycle.

## Test plan
- Forwarding priority: Rs_EX = 5; WriteReg_MEM = 5 and WriteReg_WB = 5, both RegWrite = 1 → fwdA = 10. Drop RegWrite_MEM → fwdA = 01. Set Rs_EX = 0 → fwdA = 00.
- Load-use: MemtoReg_EX = 1, Rt_EX = 8, Rs_ID = 8 → Stall_IF = Stall_ID = Flush_EX = 1, and lw_stall_cnt = 1 and stall_cnt = 1 on the next cycle.
- Branch hazard: Branch_ID = 1, Rt_ID = 3, RegWrite_EX = 1, WriteReg_EX = 3 → stall asserted, br_stall_cnt increments. Then with WriteReg_MEM = 3, RegWrite_MEM = 1, MemtoReg_MEM = 0 → no stall and SrcBfwd_ID = 1.
- Watchdog (MAX_STALL = 8): hold hz = 1 for 8 cycles → hang_err = 1 from cycle 8 and stays high after hz drops. Pulse clr_err → hang_err = 0 next cycle. Repeat with a 2-cycle hold gap in mid-run → hang_err still rises only after 8 counted cycles.
- Saturation and clear (CNT_W = 4): 20 stall cycles → stall_cnt = 15. Assert clr_cnt together with hz → stall_cnt = 0.
- Asynchronous reset while in HUNG with counters nonzero → all counters and hang_err = 0 immediately, without a clock edge.
